fp32_mul_seq: RTL and testbench
===============================

FP32_MUL_SEQ -- requirements
Module: fp32_mul_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width; only 32 (IEEE-754 binary32) is supported.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  level request from initiator; held high until done seen, then dropped.
REQ-005 value_a  input  32  multiplicand, binary32; sampled only on the accepting edge.
REQ-006 value_b  input  32  multiplier, binary32; sampled only on the accepting edge.
REQ-007 done  output  1  registered; high while result valid and start still high.
REQ-008 busy  output  1  registered; high from accepting edge until return to IDLE.
REQ-009 value_out  output  32  registered product; stable whenever done is high.

Function
REQ-010 SHALL implement the responder side of the level start/done four-phase handshake used by the gate-calculation controllers.
REQ-011 States SHALL be IDLE, MULT, NORM, ROUND, DONE.
REQ-012 IDLE: on start=1, latch operands, sign = sa xor sb, exponent sum, busy<=1, iteration counter<=0, go MULT.
REQ-013 MULT: one shift-add step of 24x24 hidden-bit mantissa product per cycle; exactly 24 cycles, then NORM.
REQ-014 NORM: if product bit 47 set, shift right 1 and increment exponent; compute guard and sticky; go ROUND.
REQ-015 ROUND: apply rounding, renormalise on mantissa carry-out, resolve specials, register value_out and set done<=1 in the same edge; go DONE.
REQ-016 Latency SHALL be fixed: done high after exactly 26 rising edges following the accepting edge, for all operand classes.
REQ-017 DONE: hold done=1 and value_out stable while start=1; on start=0, done<=0, busy<=0, go IDLE next edge.
REQ-018 No new request accepted until start observed low in DONE; start held high in DONE SHALL NOT restart.
REQ-019 start dropped early (protocol violation): computation completes, done high exactly one cycle, then IDLE.
REQ-020 Operand changes after the accepting edge SHALL NOT affect the result.
REQ-021 Exponent field 0 (zero/subnormal) SHALL be flushed to signed zero.
REQ-022 Any NaN operand, or Inf times zero, SHALL yield 0x7FC00000.
REQ-023 Inf times finite nonzero SHALL yield signed Inf.
REQ-024 Result biased exponent >=255 after rounding SHALL yield signed Inf; <=0 SHALL yield signed zero.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, done=0, busy=0, value_out=0, counter and accumulator 0, regardless of state.
REQ-026 rst has priority over start on the same edge; an in-flight operation is discarded with no done.

Configuration
REQ-027 Macro FP_MUL_RNE_EN: defined -> round-to-nearest-even from guard/sticky/LSB; undefined -> truncate toward zero (guard/sticky ignored).
REQ-028 Latency, state sequence and special-value rules SHALL be identical with or without FP_MUL_RNE_EN.

Verification
REQ-029 start=1, a=0x3FC00000, b=0x40000000 -> done on 26th edge after accept, value_out=0x40400000; drop start -> done=0 next edge, busy=0.
REQ-030 a=0x3F000000, b=0xC0800000 -> 0xC0000000; a=0x7F000000, b=0x7F000000 -> 0x7F800000; a=0x7F800000, b=0x00000000 -> 0x7FC00000.
REQ-031 a=0x3F800001, b=0x3FC00000 -> 0x3FC00002 with FP_MUL_RNE_EN, 0x3FC00001 without.
REQ-032 Hold start high 10 cycles after done -> done and value_out unchanged, no second computation; change operands meanwhile -> no effect.
REQ-033 Assert rst 10 edges after accept -> done=0, busy=0, value_out=0 next edge; new request 0x40400000*0x40000000 -> 0x40C00000 after 26 edges.
REQ-034 Drop start 5 edges after accept -> done high exactly one cycle at edge 26, then IDLE; subsequent request accepted normally.

Source files
------------

// File: rtl/fp32_mul_seq.sv
// Sequential IEEE-754 binary32 multiplier: 24-step shift-add mantissa core behind a level start/done handshake.
// Macro FP_MUL_RNE_EN selects round-to-nearest-even; left undefined the result is truncated toward zero.
module fp32_mul_seq #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] value_a,
   input  logic [DATA_WIDTH-1:0] value_b,
   output logic                  done,
   output logic                  busy,
   output logic [DATA_WIDTH-1:0] value_out
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_MULT  = 3'd1,
      S_NORM  = 3'd2,
      S_ROUND = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t             state_q;
   logic               sign_q;
   logic signed [9:0]  exp_q;
   logic [47:0]        mcand_q;
   logic [23:0]        mplier_q;
   logic [47:0]        acc_q;
   logic [4:0]         cnt_q;
   logic               nan_q;
   logic               inf_q;
   logic               zero_q;
   logic [23:0]        mant_q;
   logic               guard_q;
   logic               sticky_q;
   logic               done_q;
   logic               busy_q;
   logic [31:0]        result_q;

   logic [7:0]         exp_a;
   logic [7:0]         exp_b;
   logic [22:0]        frac_a;
   logic [22:0]        frac_b;
   logic               a_zero;
   logic               b_zero;
   logic               a_inf;
   logic               b_inf;
   logic               a_nan;
   logic               b_nan;
   logic signed [9:0]  exp_sum_d;
   logic [47:0]        acc_d;
   logic               round_up_d;
   logic [24:0]        mant_rnd_d;
   logic signed [9:0]  exp_rnd_d;
   logic [22:0]        frac_rnd_d;
   logic [31:0]        result_d;

   assign exp_a  = value_a[30:23];
   assign exp_b  = value_b[30:23];
   assign frac_a = value_a[22:0];
   assign frac_b = value_b[22:0];

   // Exponent field 0 covers both zero and subnormals, which are flushed to zero.
   assign a_zero = (exp_a == 8'd0);
   assign b_zero = (exp_b == 8'd0);
   assign a_inf  = (exp_a == 8'hFF) && (frac_a == 23'd0);
   assign b_inf  = (exp_b == 8'hFF) && (frac_b == 23'd0);
   assign a_nan  = (exp_a == 8'hFF) && (frac_a != 23'd0);
   assign b_nan  = (exp_b == 8'hFF) && (frac_b != 23'd0);

   assign exp_sum_d = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;
   assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : 48'd0);

`ifdef FP_MUL_RNE_EN
   assign round_up_d = guard_q & (sticky_q | mant_q[0]);
`else
   assign round_up_d = 1'b0;
`endif

   // A carry out of the rounded mantissa leaves 1.000..., so only the exponent moves.
   assign mant_rnd_d = {1'b0, mant_q} + {24'd0, round_up_d};
   assign exp_rnd_d  = mant_rnd_d[24] ? (exp_q + 10'sd1) : exp_q;
   assign frac_rnd_d = mant_rnd_d[24] ? mant_rnd_d[23:1] : mant_rnd_d[22:0];

   always_comb begin
      result_d = {sign_q, exp_rnd_d[7:0], frac_rnd_d};
      if (nan_q) begin
         result_d = 32'h7FC0_0000;
      end else if (inf_q) begin
         result_d = {sign_q, 8'hFF, 23'd0};
      end else if (zero_q) begin
         result_d = {sign_q, 31'd0};
      end else if (exp_rnd_d >= 10'sd255) begin
         result_d = {sign_q, 8'hFF, 23'd0};
      end else if (exp_rnd_d <= 10'sd0) begin
         result_d = {sign_q, 31'd0};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         sign_q   <= 1'b0;
         exp_q    <= 10'sd0;
         mcand_q  <= 48'd0;
         mplier_q <= 24'd0;
         acc_q    <= 48'd0;
         cnt_q    <= 5'd0;
         nan_q    <= 1'b0;
         inf_q    <= 1'b0;
         zero_q   <= 1'b0;
         mant_q   <= 24'd0;
         guard_q  <= 1'b0;
         sticky_q <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         result_q <= 32'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  sign_q   <= value_a[31] ^ value_b[31];
                  exp_q    <= exp_sum_d;
                  mcand_q  <= {24'd0, ~a_zero, frac_a};
                  mplier_q <= {~b_zero, frac_b};
                  acc_q    <= 48'd0;
                  cnt_q    <= 5'd0;
                  nan_q    <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
                  inf_q    <= a_inf | b_inf;
                  zero_q   <= a_zero | b_zero;
                  busy_q   <= 1'b1;
                  state_q  <= S_MULT;
               end
            end
            S_MULT: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 5'd1;
               if (cnt_q == 5'd23) begin
                  state_q <= S_NORM;
               end
            end
            S_NORM: begin
               // Product of two [1,2) mantissas lies in [1,4): at most one right shift.
               if (acc_q[47]) begin
                  mant_q   <= acc_q[47:24];
                  guard_q  <= acc_q[23];
                  sticky_q <= |acc_q[22:0];
                  exp_q    <= exp_q + 10'sd1;
               end else begin
                  mant_q   <= acc_q[46:23];
                  guard_q  <= acc_q[22];
                  sticky_q <= |acc_q[21:0];
               end
               state_q <= S_ROUND;
            end
            S_ROUND: begin
               result_q <= result_d;
               done_q   <= 1'b1;
               state_q  <= S_DONE;
            end
            S_DONE: begin
               if (!start) begin
                  done_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign done      = done_q;
   assign busy      = busy_q;
   assign value_out = result_q;

endmodule

// File: tb/tb_fp32_mul_seq.sv
// Randomised self-checking bench for fp32_mul_seq against an arithmetic binary32 product model.
// Honours FP_MUL_RNE_EN the same way the design does.
module tb_fp32_mul_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] value_a;
   logic [31:0] value_b;
   logic        done;
   logic        busy;
   logic [31:0] value_out;

   int n_checks = 0;
   int n_miss   = 0;

   fp32_mul_seq #(.DATA_WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .value_a   (value_a),
      .value_b   (value_b),
      .done      (done),
      .busy      (busy),
      .value_out (value_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
      n_checks++;
      if (got !== exp_v) begin
         n_miss++;
         $display("FAIL %s: got %08h, expected %08h (t=%0t)", tag, got, exp_v, $time);
      end
   endtask

   // Exact integer product, scaled down to a 24-bit significand, then rounded by remainder comparison.
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      longint unsigned ma;
      longint unsigned mb;
      longint unsigned p;
      longint unsigned q;
      longint unsigned r;
      longint unsigned half;
      int              ea;
      int              eb;
      int              e;
      int              sh;
      logic            s;
      logic [7:0]      e8;
      logic [22:0]     f23;
      bit              a_nan;
      bit              b_nan;
      bit              a_inf;
      bit              b_inf;
      bit              a_zero;
      bit              b_zero;
      ea     = int'(a[30:23]);
      eb     = int'(b[30:23]);
      s      = a[31] ^ b[31];
      a_nan  = (ea == 255) && (a[22:0] != 23'd0);
      b_nan  = (eb == 255) && (b[22:0] != 23'd0);
      a_inf  = (ea == 255) && (a[22:0] == 23'd0);
      b_inf  = (eb == 255) && (b[22:0] == 23'd0);
      a_zero = (ea == 0);
      b_zero = (eb == 0);
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC0_0000;
      if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
      if (a_zero || b_zero) return {s, 31'd0};
      ma = 64'h80_0000 + 64'(a[22:0]);
      mb = 64'h80_0000 + 64'(b[22:0]);
      p  = ma * mb;
      e  = ea + eb - 127;
      if (p >= (64'd1 << 47)) begin
         sh = 24;
         e  = e + 1;
      end else begin
         sh = 23;
      end
      q    = p >> sh;
      r    = p - (q << sh);
      half = 64'd1 << (sh - 1);
`ifdef FP_MUL_RNE_EN
      if ((r > half) || ((r == half) && (q % 2 == 1))) q = q + 1;
`else
      if (r > half) q = q; // truncation discards the remainder
`endif
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         e = e + 1;
      end
      if (e >= 255) return {s, 8'hFF, 23'd0};
      if (e <= 0) return {s, 31'd0};
      e8  = 8'(e);
      f23 = 23'(q);
      return {s, e8, f23};
   endfunction

   function automatic logic [31:0] rand_op();
      logic        s;
      logic [7:0]  e8;
      logic [22:0] m;
      s = 1'($urandom_range(0, 1));
      m = 23'($urandom());
      case ($urandom_range(0, 11))
         0:       return {s, 31'd0};
         1:       return {s, 8'hFF, 23'd0};
         2:       return {s, 8'hFF, m | 23'd1};
         3:       return {s, 8'h00, m};
         4:       e8 = 8'($urandom_range(190, 254));
         5:       e8 = 8'($urandom_range(1, 64));
         6:       e8 = 8'($urandom_range(1, 254));
         default: e8 = 8'($urandom_range(100, 154));
      endcase
      return {s, e8, m};
   endfunction

   // One full transaction; drop_at > 0 releases start early, hold_cycles keeps start high after done.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_v,
                        input int drop_at, input int hold_cycles);
      @(negedge clk);
      value_a = a;
      value_b = b;
      start   = 1'b1;
      @(posedge clk);
      #1;
      check("busy_after_accept", {31'd0, busy}, 32'd1);
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         value_a = $urandom();
         value_b = $urandom();
         if (k == drop_at) start = 1'b0;
         @(posedge clk);
         #1;
      end
      check("done_early_edge25", {31'd0, done}, 32'd0);
      @(posedge clk);
      #1;
      check("done_edge26", {31'd0, done}, 32'd1);
      check("value_out", value_out, exp_v);
      for (int h = 0; h < hold_cycles; h++) begin
         @(negedge clk);
         value_a = $urandom();
         value_b = $urandom();
         @(posedge clk);
         #1;
         check("hold_done", {31'd0, done}, 32'd1);
         check("hold_busy", {31'd0, busy}, 32'd1);
         check("hold_value", value_out, exp_v);
      end
      if (drop_at <= 0) begin
         @(negedge clk);
         start = 1'b0;
      end
      @(posedge clk);
      #1;
      check("done_after_drop", {31'd0, done}, 32'd0);
      check("busy_after_drop", {31'd0, busy}, 32'd0);
      $display("op %08h * %08h -> %08h (expected %08h)", a, b, value_out, exp_v);
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] exp31;
      rst     = 1'b1;
      start   = 1'b0;
      value_a = 32'd0;
      value_b = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_value", value_out, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      do_op(32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 0, 0);
      do_op(32'h3F00_0000, 32'hC080_0000, 32'hC000_0000, 0, 0);
      do_op(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 0, 0);
      do_op(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 0, 0);
      do_op(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 0, 0);
      do_op(32'h8080_0000, 32'h3F00_0000, 32'h8000_0000, 0, 0);
      do_op(32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 0, 0);
`ifdef FP_MUL_RNE_EN
      exp31 = 32'h3FC0_0002;
`else
      exp31 = 32'h3FC0_0001;
`endif
      do_op(32'h3F80_0001, 32'h3FC0_0000, exp31, 0, 0);

      do_op(32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 0, 10);

      // Reset lands on the 10th edge after accept with start still high.
      @(negedge clk);
      value_a = 32'h3FC0_0000;
      value_b = 32'h3FC0_0000;
      start   = 1'b1;
      @(posedge clk);
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_mid_done", {31'd0, done}, 32'd0);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_value", value_out, 32'd0);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      check("rst_no_late_done", {31'd0, done}, 32'd0);
      $display("op reset mid-flight discarded");
      do_op(32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 0, 0);

      do_op(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 5, 0);
      do_op(32'h3F00_0000, 32'hC080_0000, 32'hC000_0000, 0, 0);

      for (int i = 0; i < 150; i++) begin
         ra = rand_op();
         rb = rand_op();
         do_op(ra, rb, ref_mul(ra, rb), 0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
      $finish;
   end

endmodule
